hasty_flow_sequencer: RTL and testbench
=======================================

// Module: hasty_flow_sequencer
// PURPOSE
//  Drives the five port valves (p1..p5) of the 8-trap long-cell-trap array through a fixed
//  assay protocol: prime, cell load, settle, N x (reagent, wash), flush. Sits directly
//  upstream of the trap array; valve_open[4:0] maps 1:1 onto array ports p1..p5.
//  Enforces break-before-make dead time between valve sets and a pressure-loss watchdog.
// PARAMETERS
//  PRIME_T   64   cycles valves held in PRIME
//  LOAD_T    256  cycles in LOAD
//  SETTLE_T  128  cycles in SETTLE (all closed, cells settle into traps)
//  REAG_T    128  cycles in REAGENT
//  WASH_T    128  cycles in WASH
//  FLUSH_T   64   cycles in FLUSH
//  DEAD_T    2    all-closed gap cycles between consecutive phases (>=1)
//  PRESS_TO  8    consecutive pressure_ok=0 cycles in a flow phase that trip ERROR
//  CYC_W     4    width of cycles_cfg / cycle_cnt
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  start        in   1      pulse; begins protocol when in IDLE, ignored otherwise
//  abort        in   1      return to IDLE from any state (also clears ERROR)
//  pressure_ok  in   1      supply pressure in range
//  cycles_cfg   in   CYC_W  reagent/wash repetitions; latched on accepted start
//  valve_open   out  5      bit0=p1 cells, bit1=p2 reagent, bit2=p3 buffer, bit3=p4 out, bit4=p5 out
//  phase        out  4      0 IDLE,1 GAP,2 PRIME,3 LOAD,4 SETTLE,5 REAGENT,6 WASH,7 FLUSH,8 DONE,9 ERROR
//  busy         out  1      1 in every state except IDLE, DONE, ERROR
//  done         out  1      one-cycle pulse, high exactly while phase==DONE
//  error        out  1      high while in ERROR
//  cycle_cnt    out  CYC_W  completed REAGENT+WASH pairs this run
// BEHAVIOUR
//  - Reset: state IDLE, valve_open=0, busy=0, done=0, error=0, cycle_cnt=0, timers/watchdog=0.
//  - All outputs registered (decoded from state register); no combinational input->output paths.
//  - Valve sets: PRIME/FLUSH 5'b11100, LOAD 5'b01001, SETTLE 0, REAGENT 5'b11010, WASH 5'b10100;
//    IDLE/GAP/DONE/ERROR 0.
//  - Order: IDLE->PRIME->LOAD->SETTLE->{REAGENT->WASH}xN->FLUSH->DONE->IDLE, N=latched cycles_cfg;
//    N=0 goes SETTLE->FLUSH. Every transition into PRIME..FLUSH passes through GAP for DEAD_T
//    cycles first (GAP holds next-phase target). DONE lasts 1 cycle then IDLE, no GAP.
//  - Timing: start high in IDLE at cycle t -> GAP at t+1..t+DEAD_T, PRIME at t+1+DEAD_T for
//    exactly PRIME_T cycles; each phase occupies exactly its *_T cycles (down-counter loaded on entry).
//  - cycle_cnt cleared on accepted start; increments by 1 on WASH exit; holds after DONE until next start.
//  - Watchdog: in flow phases (PRIME, LOAD, REAGENT, WASH, FLUSH) counts consecutive
//    pressure_ok=0; cleared on pressure_ok=1 and on any phase entry; ignored in SETTLE/GAP.
//    Count reaching PRESS_TO -> ERROR next cycle (valves 0). Phase timer keeps running meanwhile.
//  - ERROR: sticky; start ignored; abort -> IDLE next cycle. cycle_cnt holds.
//  - abort (any state, priority over start, timer expiry and watchdog) -> IDLE next cycle,
//    valve_open=0, done not pulsed. start+abort same cycle in IDLE -> stays IDLE.
//  - rst mid-run: all state and outputs to reset values next edge, regardless of phase.
//  - Timers sized $clog2(max *_T)+1; cycle_cnt never wraps (N <= 2^CYC_W-1).
// TESTING
//  - Full run cycles_cfg=2, pressure_ok=1: phase trace 1,2,1,3,1,4,1,5,1,6,1,5,1,6,1,7,8,0;
//    PRIME starts t+3 (DEAD_T=2); done 1 cycle; cycle_cnt=2; valve_open matches table every cycle.
//  - cycles_cfg=0: SETTLE->GAP->FLUSH, no REAGENT seen, cycle_cnt=0, done pulses.
//  - Break-before-make: assert valve_open==0 for DEAD_T cycles between every pair of flow phases;
//    never any cycle where p1 and p2 open together.
//  - Watchdog: in LOAD drop pressure_ok 7 cycles, raise -> no error; later drop 8 cycles ->
//    phase=9, error=1, valves 0; start ignored; abort -> IDLE, error=0.
//  - abort in WASH of cycle 2 -> IDLE next cycle, done never 1, cycle_cnt=1 held.
//  - rst asserted during REAGENT -> all outputs reset values next cycle; start then runs cleanly.

Source files
------------

// File: rtl/hasty_flow_sequencer.sv
// Assay valve sequencer for the 8-trap long-cell-trap array.
// Walks prime -> load -> settle -> N x (reagent, wash) -> flush, inserting an
// all-closed dead-time gap before every flow phase and tripping to ERROR when
// supply pressure stays low for too long during a flow phase.
module hasty_flow_sequencer #(
  parameter int PRIME_T  = 64,
  parameter int LOAD_T   = 256,
  parameter int SETTLE_T = 128,
  parameter int REAG_T   = 128,
  parameter int WASH_T   = 128,
  parameter int FLUSH_T  = 64,
  parameter int DEAD_T   = 2,
  parameter int PRESS_TO = 8,
  parameter int CYC_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pressure_ok,
  input  logic [CYC_W-1:0] cycles_cfg,
  output logic [4:0]       valve_open,
  output logic [3:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CYC_W-1:0] cycle_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(PRIME_T, LOAD_T), max2(SETTLE_T, REAG_T)),
                              max2(max2(WASH_T, FLUSH_T), DEAD_T));
  localparam int T_W   = $clog2(MAX_T) + 1;
  localparam int WD_W  = $clog2(PRESS_TO) + 1;

  localparam logic [T_W-1:0]  GAP_LEN = T_W'(DEAD_T - 1);
  localparam logic [T_W-1:0]  T_ONE   = T_W'(1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(PRESS_TO - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [CYC_W-1:0] C_ONE  = CYC_W'(1);

  // Encoding doubles as the externally visible phase code.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GAP     = 4'd1,
    S_PRIME   = 4'd2,
    S_LOAD    = 4'd3,
    S_SETTLE  = 4'd4,
    S_REAGENT = 4'd5,
    S_WASH    = 4'd6,
    S_FLUSH   = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_t;

  state_t           state, state_n;
  state_t           target, target_n;
  logic [T_W-1:0]   timer, timer_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic [CYC_W-1:0] n_cfg, n_n;
  logic [CYC_W-1:0] cnt, cnt_n;
  logic             flow;

  // Down-counter reload value for a phase (counter expires at zero).
  function automatic logic [T_W-1:0] phase_len(input state_t s);
    case (s)
      S_PRIME:   phase_len = T_W'(PRIME_T - 1);
      S_LOAD:    phase_len = T_W'(LOAD_T - 1);
      S_SETTLE:  phase_len = T_W'(SETTLE_T - 1);
      S_REAGENT: phase_len = T_W'(REAG_T - 1);
      S_WASH:    phase_len = T_W'(WASH_T - 1);
      S_FLUSH:   phase_len = T_W'(FLUSH_T - 1);
      default:   phase_len = '0;
    endcase
  endfunction

  // Phases during which fluid moves and the pressure watchdog is armed.
  function automatic logic is_flow(input state_t s);
    return (s == S_PRIME) || (s == S_LOAD) || (s == S_REAGENT) ||
           (s == S_WASH) || (s == S_FLUSH);
  endfunction

  // State, timer, watchdog and run-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      target <= S_IDLE;
      timer  <= '0;
      wd     <= '0;
      n_cfg  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      target <= target_n;
      timer  <= timer_n;
      wd     <= wd_n;
      n_cfg  <= n_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state logic: abort first, then watchdog trip, then phase timer expiry.
  always_comb begin
    state_n  = state;
    target_n = target;
    timer_n  = timer;
    wd_n     = wd;
    n_n      = n_cfg;
    cnt_n    = cnt;
    flow     = is_flow(state);
    if (abort) begin
      state_n = S_IDLE;
      timer_n = '0;
      wd_n    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n  = S_GAP;
            target_n = S_PRIME;
            timer_n  = GAP_LEN;
            wd_n     = '0;
            n_n      = cycles_cfg;
            cnt_n    = '0;
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            state_n = target;
            timer_n = phase_len(target);
            wd_n    = '0;
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        S_DONE:  state_n = S_IDLE;
        S_ERROR: state_n = S_ERROR;
        default: begin
          if (flow && !pressure_ok && (wd == WD_LAST)) begin
            state_n = S_ERROR;
            timer_n = '0;
            wd_n    = '0;
          end else begin
            wd_n = (flow && !pressure_ok) ? (wd + WD_ONE) : '0;
            if (timer == '0) begin
              wd_n    = '0;
              timer_n = GAP_LEN;
              state_n = S_GAP;
              case (state)
                S_PRIME:   target_n = S_LOAD;
                S_LOAD:    target_n = S_SETTLE;
                S_SETTLE:  target_n = (n_cfg == '0) ? S_FLUSH : S_REAGENT;
                S_REAGENT: target_n = S_WASH;
                S_WASH: begin
                  cnt_n    = cnt + C_ONE;
                  target_n = ((cnt + C_ONE) == n_cfg) ? S_FLUSH : S_REAGENT;
                end
                default: begin
                  // FLUSH finishes straight into the one-cycle DONE, no gap.
                  state_n = S_DONE;
                  timer_n = '0;
                end
              endcase
            end else begin
              timer_n = timer - T_ONE;
            end
          end
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    case (state)
      S_PRIME, S_FLUSH: valve_open = 5'b11100;
      S_LOAD:           valve_open = 5'b01001;
      S_REAGENT:        valve_open = 5'b11010;
      S_WASH:           valve_open = 5'b10100;
      default:          valve_open = 5'b00000;
    endcase
    phase     = state;
    busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    done      = (state == S_DONE);
    error     = (state == S_ERROR);
    cycle_cnt = cnt;
  end

endmodule

// File: tb/tb_hasty_flow_sequencer.sv
// Bench for hasty_flow_sequencer: a per-cycle schedule model of the assay
// protocol (queue of expected phase codes) compared against the DUT each cycle.
module tb_hasty_flow_sequencer;
  localparam int PRIME_T = 64, LOAD_T = 256, SETTLE_T = 128, REAG_T = 128;
  localparam int WASH_T = 128, FLUSH_T = 64, DEAD_T = 2, PRESS_TO = 8, CYC_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pressure_ok = 1'b1;
  logic [CYC_W-1:0] cycles_cfg = '0;
  logic [4:0]       valve_open;
  logic [3:0]       phase;
  logic             busy, done, error;
  logic [CYC_W-1:0] cycle_cnt;

  hasty_flow_sequencer #(
    .PRIME_T(PRIME_T), .LOAD_T(LOAD_T), .SETTLE_T(SETTLE_T), .REAG_T(REAG_T),
    .WASH_T(WASH_T), .FLUSH_T(FLUSH_T), .DEAD_T(DEAD_T), .PRESS_TO(PRESS_TO),
    .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pressure_ok(pressure_ok),
    .cycles_cfg(cycles_cfg), .valve_open(valve_open), .phase(phase), .busy(busy),
    .done(done), .error(error), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  int checks = 0;
  int errors = 0;

  // Model state: current expected phase, future schedule, watchdog, pair count.
  int cur = 0;
  int wd = 0;
  int ecnt = 0;
  int q[$];
  int done_seen = 0;
  int reag_seen = 0;
  bit trace_on = 0;
  int last_ph = 0;
  int tr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] valves_of(input int p);
    case (p)
      2, 7:    return 5'b11100;
      3:       return 5'b01001;
      5:       return 5'b11010;
      6:       return 5'b10100;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic bit is_flow(input int p);
    return (p == 2) || (p == 3) || (p == 5) || (p == 6) || (p == 7);
  endfunction

  task automatic seg(input int p, input int n);
    for (int i = 0; i < n; i++) q.push_back(p);
  endtask

  // Whole protocol schedule for one accepted start with n repetitions.
  task automatic build(input int n);
    q.delete();
    seg(1, DEAD_T); seg(2, PRIME_T);
    seg(1, DEAD_T); seg(3, LOAD_T);
    seg(1, DEAD_T); seg(4, SETTLE_T);
    for (int k = 0; k < n; k++) begin
      seg(1, DEAD_T); seg(5, REAG_T);
      seg(1, DEAD_T); seg(6, WASH_T);
    end
    seg(1, DEAD_T); seg(7, FLUSH_T);
    seg(8, 1);
  endtask

  // One clock: advance model from the inputs now applied, then compare.
  task automatic step();
    int nxt;
    if (rst) begin
      q.delete(); nxt = 0; wd = 0; ecnt = 0;
    end else if (abort) begin
      q.delete(); nxt = 0; wd = 0;
    end else if (cur == 0) begin
      if (start) begin
        build(int'(cycles_cfg)); ecnt = 0; nxt = q.pop_front();
      end else nxt = 0;
      wd = 0;
    end else if (cur == 9) begin
      nxt = 9;
    end else if (is_flow(cur) && !pressure_ok && wd == PRESS_TO - 1) begin
      q.delete(); nxt = 9; wd = 0;
    end else begin
      nxt = (q.size() > 0) ? q.pop_front() : 0;
      if (cur == 6 && nxt == 1) ecnt++;
      wd = (nxt == cur && is_flow(cur) && !pressure_ok) ? wd + 1 : 0;
    end
    @(posedge clk);
    #1;
    cur = nxt;
    if (cur == 8) done_seen++;
    if (cur == 5) reag_seen++;
    if (trace_on && cur != last_ph) tr.push_back(cur);
    last_ph = cur;
    chk("phase", phase, cur);
    chk("valve_open", valve_open, valves_of(cur));
    chk("busy", busy, (cur != 0 && cur != 8 && cur != 9));
    chk("done", done, (cur == 8));
    chk("error", error, (cur == 9));
    chk("cycle_cnt", cycle_cnt, ecnt);
    chk("p1_p2_exclusive", valve_open[0] & valve_open[1], 0);
  endtask

  task automatic pulse_start(input int n);
    cycles_cfg = CYC_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int limit);
    int g = 0;
    while (cur != 0 && g < limit) begin step(); g++; end
    chk(tag, phase, 0);
  endtask

  int exp_tr[18] = '{1, 2, 1, 3, 1, 4, 1, 5, 1, 6, 1, 5, 1, 6, 1, 7, 8, 0};

  initial begin
    int g;
    int drop;
    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_phase", phase, 0);
    chk("reset_valves", valve_open, 0);
    chk("reset_cnt", cycle_cnt, 0);
    step();

    // Full run, two repetitions, with recorded phase trace
    trace_on = 1; last_ph = 0; tr.delete(); done_seen = 0;
    pulse_start(2);
    chk("gap_after_start", phase, 1);
    step();
    chk("gap_second", phase, 1);
    step();
    chk("prime_at_t3", phase, 2);
    run_to_idle("full_run_idle", 3000);
    trace_on = 0;
    chk("trace_len", tr.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < tr.size()) chk("trace_entry", tr[i], exp_tr[i]);
    chk("full_done_cycles", done_seen, 1);
    chk("full_cycle_cnt", cycle_cnt, 2);

    // Zero repetitions: SETTLE goes straight to FLUSH
    done_seen = 0; reag_seen = 0;
    pulse_start(0);
    cycles_cfg = 4'd5;
    run_to_idle("zero_run_idle", 2000);
    chk("zero_no_reagent", reag_seen, 0);
    chk("zero_done", done_seen, 1);
    chk("zero_cnt", cycle_cnt, 0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", phase, 0);

    // Watchdog: 7 low cycles tolerated, 8 trip ERROR
    pulse_start(1);
    g = 0;
    while (cur != 3 && g < 500) begin step(); g++; end
    chk("reach_load", phase, 3);
    for (int i = 0; i < 10; i++) step();
    pressure_ok = 1'b0;
    for (int i = 0; i < 7; i++) step();
    pressure_ok = 1'b1;
    step();
    chk("wd_7_no_error", error, 0);
    for (int i = 0; i < 20; i++) step();
    pressure_ok = 1'b0;
    for (int i = 0; i < 8; i++) step();
    pressure_ok = 1'b1;
    chk("wd_trip_phase", phase, 9);
    chk("wd_trip_error", error, 1);
    chk("wd_trip_valves", valve_open, 0);
    pulse_start(2);
    step();
    chk("error_ignores_start", phase, 9);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_clears_error", error, 0);
    chk("abort_error_idle", phase, 0);

    // abort during WASH of the second repetition
    done_seen = 0;
    pulse_start(3);
    g = 0;
    while (!(cur == 6 && ecnt == 1) && g < 3000) begin step(); g++; end
    chk("reach_wash2", phase, 6);
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_wash_idle", phase, 0);
    chk("abort_wash_valves", valve_open, 0);
    for (int i = 0; i < 3; i++) step();
    chk("abort_cnt_held", cycle_cnt, 1);
    chk("abort_no_done", done_seen, 0);

    // rst during REAGENT, then a clean run
    pulse_start(2);
    g = 0;
    while (cur != 5 && g < 2000) begin step(); g++; end
    chk("reach_reagent", phase, 5);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_phase", phase, 0);
    chk("rst_mid_valves", valve_open, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", cycle_cnt, 0);
    done_seen = 0;
    pulse_start(1);
    run_to_idle("after_rst_idle", 2000);
    chk("after_rst_done", done_seen, 1);
    chk("after_rst_cnt", cycle_cnt, 1);

    // Randomized runs: pressure dropouts, config churn, occasional abort
    for (int r = 0; r < 6; r++) begin
      pulse_start(int'($urandom_range(0, 3)));
      drop = 0; g = 0;
      while (cur != 0 && cur != 9 && g < 4000) begin
        if (drop > 0) drop--;
        else if ($urandom_range(0, 299) == 0) drop = int'($urandom_range(3, 10));
        pressure_ok = (drop == 0);
        cycles_cfg = CYC_W'($urandom);
        abort = ($urandom_range(0, 2999) == 0);
        step();
        g++;
      end
      abort = 1'b0; pressure_ok = 1'b1;
      chk("rand_run_ended", (g < 4000), 1);
      if (cur == 9) begin
        abort = 1'b1; step(); abort = 1'b0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
